pixel_stream_capture: RTL and testbench

- Sink end of the pixel streaming interface: consumes the `en`-qualified 32-bit result stream emitted by the filter cores (e.g. SobelX) and packs the low byte of each beat into an on-chip frame buffer.
- Discards a programmable number of pipeline-fill beats, counts exactly one frame of pixels, then flags completion.
- A host or bench reads the captured frame back through a registered read port and writes it out as BMP pixel data.

---
 rtl/pixel_stream_pkg.sv | 26 ++
 rtl/pixel_capture_ram.sv | 52 +++++
 rtl/pixel_stream_capture.sv | 145 ++++++++++++++
 tb/tb_pixel_stream_capture.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_stream_pkg.sv
// Shared definitions for the pixel streaming sink and the filter cores:
// capture FSM state encoding, pixel width, and the signed-to-pixel clamp.
package pixel_stream_pkg;

  localparam int PIX_W  = 8;
  localparam int BEAT_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SKIP    = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } capture_state_e;

  // Saturate a signed stream value into the 0..255 pixel range.
  function automatic logic [PIX_W-1:0] clamp_pixel(input logic signed [BEAT_W-1:0] v);
    if (v < 0) begin
      return '0;
    end else if (v > 255) begin
      return '1;
    end else begin
      return v[PIX_W-1:0];
    end
  endfunction

endpackage

// File: rtl/pixel_capture_ram.sv
// Frame buffer: DEPTH x 8 bit, one write port, one registered read port.
// A read colliding with a write to the same address returns the old byte;
// addresses at or beyond DEPTH read as 0 and never write.
module pixel_capture_ram
  import pixel_stream_pkg::*;
#(
  parameter int DEPTH  = 2000000,
  parameter int ADDR_W = 21
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PIX_W-1:0]  rd_data
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  logic [PIX_W-1:0] mem [DEPTH];

  logic             wr_ok;
  logic             rd_ok;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  assign wr_ok  = wr_en && ({1'b0, wr_addr} < DEPTH_X);
  assign rd_ok  = ({1'b0, rd_addr} < DEPTH_X);
  assign wr_idx = wr_addr[IDX_W-1:0];
  assign rd_idx = rd_addr[IDX_W-1:0];

  // Write port; contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Registered read port, one cycle latency, read-before-write on collision.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_ok) begin
      rd_data <= mem[rd_idx];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: rtl/pixel_stream_capture.sv
// Sink for the en-qualified filter result stream. Drops SKIP_N pipeline-fill
// beats after start, stores one frame of pixel bytes, then flags completion.
// Define CAPTURE_CLAMP_EN to saturate signed beats into 0..255 instead of
// keeping the low byte verbatim.
module pixel_stream_capture
  import pixel_stream_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2000000,
  parameter int ADDR_W = 21,
  parameter int SKIP_N = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] frame_len,
  input  logic              en,
  input  logic [DATA_W-1:0] stream_in,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow,
  output logic [ADDR_W-1:0] wr_count,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PIX_W-1:0]  rd_data
);

  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] SKIP_LAST = (SKIP_N > 0) ? ADDR_W'(SKIP_N - 1) : '0;

  capture_state_e    state_reg, state_next;
  logic [ADDR_W-1:0] len_reg, len_next;
  logic [ADDR_W-1:0] wr_count_reg, wr_count_next;
  logic [ADDR_W-1:0] skip_cnt_reg, skip_cnt_next;
  logic              overflow_reg, overflow_next;
  logic              frame_done_reg, frame_done_next;

  logic              arm;
  logic              wr_en;
  logic [PIX_W-1:0]  pix_byte;

`ifdef CAPTURE_CLAMP_EN
  assign pix_byte = clamp_pixel(BEAT_W'($signed(stream_in)));
`else
  // Upper beat bits have no consumer when the low byte is stored verbatim.
  logic unused_beat_bits;
  assign unused_beat_bits = ^stream_in[DATA_W-1:PIX_W];
  assign pix_byte = stream_in[PIX_W-1:0];
`endif

  // A zero-length start is ignored in every state.
  assign arm = start && (frame_len != '0);

  // Next-state and datapath control; a valid start overrides any beat.
  always_comb begin
    state_next      = state_reg;
    len_next        = len_reg;
    wr_count_next   = wr_count_reg;
    skip_cnt_next   = skip_cnt_reg;
    overflow_next   = overflow_reg;
    frame_done_next = 1'b0;
    wr_en           = 1'b0;

    if (arm) begin
      if ({1'b0, frame_len} > DEPTH_X) begin
        len_next = DEPTH_X[ADDR_W-1:0];
      end else begin
        len_next = frame_len;
      end
      wr_count_next = '0;
      skip_cnt_next = '0;
      overflow_next = 1'b0;
      state_next    = (SKIP_N > 0) ? SKIP : CAPTURE;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next = IDLE;
        end
        SKIP: begin
          if (en) begin
            skip_cnt_next = skip_cnt_reg + ADDR_W'(1);
            if (skip_cnt_reg == SKIP_LAST) begin
              state_next = CAPTURE;
            end
          end
        end
        CAPTURE: begin
          if (en) begin
            wr_en         = 1'b1;
            wr_count_next = wr_count_reg + ADDR_W'(1);
            if (wr_count_reg == len_reg - ADDR_W'(1)) begin
              state_next      = DONE;
              frame_done_next = 1'b1;
            end
          end
        end
        DONE: begin
          if (en) begin
            overflow_next = 1'b1;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      len_reg        <= '0;
      wr_count_reg   <= '0;
      skip_cnt_reg   <= '0;
      overflow_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      len_reg        <= len_next;
      wr_count_reg   <= wr_count_next;
      skip_cnt_reg   <= skip_cnt_next;
      overflow_reg   <= overflow_next;
      frame_done_reg <= frame_done_next;
    end
  end

  assign busy       = (state_reg == SKIP) || (state_reg == CAPTURE);
  assign frame_done = frame_done_reg;
  assign overflow   = overflow_reg;
  assign wr_count   = wr_count_reg;

  pixel_capture_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_count_reg),
    .wr_data (pix_byte),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_pixel_stream_capture.sv
// Directed bench for pixel_stream_capture with a small 16-byte buffer and
// SKIP_N=2. Expected byte values follow CAPTURE_CLAMP_EN when it is defined.
module tb_pixel_stream_capture;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 5;
  localparam int SKIP_N = 2;

`ifdef CAPTURE_CLAMP_EN
  localparam logic [7:0] NEG_BYTE = 8'h00;
  localparam logic [7:0] BIG_BYTE = 8'hFF;
`else
  localparam logic [7:0] NEG_BYTE = 8'h38;
  localparam logic [7:0] BIG_BYTE = 8'h2C;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] frame_len = '0;
  logic              en = 1'b0;
  logic [DATA_W-1:0] stream_in = '0;
  logic              busy;
  logic              frame_done;
  logic              overflow;
  logic [ADDR_W-1:0] wr_count;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [7:0]        rd_data;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pixel_stream_capture #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .SKIP_N (SKIP_N)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .frame_len  (frame_len),
    .en         (en),
    .stream_in  (stream_in),
    .busy       (busy),
    .frame_done (frame_done),
    .overflow   (overflow),
    .wr_count   (wr_count),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    $display("vec %0d %s observed=%0h expected=%0h", vectors, tag, obs, exp);
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic arm(input logic [ADDR_W-1:0] len);
    start = 1'b1;
    frame_len = len;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d);
    en = 1'b1;
    stream_in = d;
    tick();
    en = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [ADDR_W-1:0] a, input logic [7:0] exp);
    rd_addr = a;
    tick();
    check(tag, {24'h0, rd_data}, {24'h0, exp});
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", frame_done, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_wrcnt", wr_count, 0);
    check("rst_rddata", rd_data, 0);

    // Contiguous frame: two fill beats then four pixels
    arm(5'd4);
    check("a_busy_arm", busy, 1'b1);
    beat(32'h11);
    beat(32'h22);
    beat(32'h33);
    check("a_wrcnt1", wr_count, 1);
    beat(32'h44);
    beat(32'h55);
    check("a_done_early", frame_done, 1'b0);
    check("a_wrcnt3", wr_count, 3);
    beat(32'h66);
    check("a_done", frame_done, 1'b1);
    check("a_busy_fall", busy, 1'b0);
    check("a_wrcnt4", wr_count, 4);
    tick();
    check("a_done_pulse", frame_done, 1'b0);
    read_chk("a_mem0", 5'd0, 8'h33);
    read_chk("a_mem1", 5'd1, 8'h44);
    read_chk("a_mem2", 5'd2, 8'h55);
    read_chk("a_mem3", 5'd3, 8'h66);

    // Same frame shape with en low on alternate cycles
    arm(5'd4);
    beat(32'h71); tick();
    beat(32'h72); tick();
    check("b_busy", busy, 1'b1);
    check("b_wrcnt0", wr_count, 0);
    beat(32'h73); tick();
    check("b_wrcnt1", wr_count, 1);
    beat(32'h74); tick();
    beat(32'h75); tick();
    check("b_done_early", frame_done, 1'b0);
    check("b_wrcnt3", wr_count, 3);
    beat(32'h76);
    check("b_done", frame_done, 1'b1);
    check("b_busy_fall", busy, 1'b0);
    read_chk("b_mem0", 5'd0, 8'h73);
    read_chk("b_mem3", 5'd3, 8'h76);

    // Beat after DONE sets sticky overflow; re-arm clears it
    check("c_ovf0", overflow, 1'b0);
    beat(32'h99);
    check("c_ovf1", overflow, 1'b1);
    check("c_wrcnt_hold", wr_count, 4);
    tick();
    tick();
    check("c_ovf_sticky", overflow, 1'b1);
    arm(5'd3);
    check("c_ovf_clr", overflow, 1'b0);
    check("c_busy", busy, 1'b1);
    check("c_wrcnt_clr", wr_count, 0);
    beat(32'h01);
    beat(32'h02);
    beat(32'hFFFF_FF38);
    beat(32'h0000_012C);
    beat(32'h5A);
    check("c_done", frame_done, 1'b1);
    check("c_wrcnt3", wr_count, 3);
    read_chk("c_neg", 5'd0, NEG_BYTE);
    read_chk("c_big", 5'd1, BIG_BYTE);
    read_chk("c_mem2", 5'd2, 8'h5A);

    // Abort mid-capture with a new start; the beat alongside start is dropped
    arm(5'd8);
    beat(32'h01);
    beat(32'h02);
    beat(32'hA0);
    beat(32'hA1);
    beat(32'hA2);
    check("d_wrcnt3", wr_count, 3);
    start = 1'b1;
    frame_len = 5'd8;
    en = 1'b1;
    stream_in = 32'hEE;
    tick();
    start = 1'b0;
    en = 1'b0;
    check("d_wrcnt_restart", wr_count, 0);
    check("d_busy", busy, 1'b1);
    check("d_no_done", frame_done, 1'b0);
    beat(32'h03);
    beat(32'h04);
    check("d_skip_again", wr_count, 0);
    beat(32'hB0);
    check("d_wrcnt1", wr_count, 1);
    for (int i = 1; i < 7; i++) beat(32'hB0 + i);
    check("d_done_early", frame_done, 1'b0);
    beat(32'hB7);
    check("d_done", frame_done, 1'b1);
    check("d_wrcnt8", wr_count, 8);
    read_chk("d_mem0", 5'd0, 8'hB0);
    read_chk("d_mem7", 5'd7, 8'hB7);

    // Reset mid-capture after five pixels; buffer survives
    arm(5'd10);
    beat(32'h01);
    beat(32'h02);
    for (int i = 0; i < 5; i++) beat(32'hC0 + i);
    check("e_wrcnt5", wr_count, 5);
    rst_n = 1'b0;
    tick();
    check("e_busy", busy, 1'b0);
    check("e_wrcnt", wr_count, 0);
    check("e_ovf", overflow, 1'b0);
    check("e_done", frame_done, 1'b0);
    check("e_rddata", rd_data, 0);
    rst_n = 1'b1;
    read_chk("e_mem0", 5'd0, 8'hC0);
    read_chk("e_mem4", 5'd4, 8'hC4);
    arm(5'd0);
    check("e_len0_idle", busy, 1'b0);
    beat(32'h33);
    check("e_idle_ovf", overflow, 1'b0);
    check("e_idle_wrcnt", wr_count, 0);

    // Length clamped to DEPTH, collision read, out-of-range read
    arm(5'd20);
    beat(32'h01);
    beat(32'h02);
    rd_addr = 5'd0;
    beat(32'h40);
    check("f_collide_old", rd_data, 8'hC0);
    tick();
    check("f_read_new", rd_data, 8'h40);
    for (int i = 1; i < 15; i++) beat(32'h40 + i);
    check("f_done_early", frame_done, 1'b0);
    check("f_wrcnt15", wr_count, 15);
    beat(32'h4F);
    check("f_done", frame_done, 1'b1);
    check("f_wrcnt16", wr_count, 16);
    check("f_busy_fall", busy, 1'b0);
    read_chk("f_mem15", 5'd15, 8'h4F);
    read_chk("f_oor16", 5'd16, 8'h00);
    read_chk("f_oor31", 5'd31, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
